// File: rtl/core_sequencer_pkg.sv
// Shared stage numbers, instruction-class codes and class-decode helpers
// for the Pillar core sequencer.
package core_sequencer_pkg;

  localparam logic [2:0] STG_IDLE   = 3'd0;
  localparam logic [2:0] STG_FETCH  = 3'd1;
  localparam logic [2:0] STG_DECODE = 3'd2;
  localparam logic [2:0] STG_EXEC   = 3'd3;
  localparam logic [2:0] STG_MEM    = 3'd4;
  localparam logic [2:0] STG_WB     = 3'd5;

  localparam logic [4:0] IT_RTYPE  = 5'd0;
  localparam logic [4:0] IT_ITYPE  = 5'd1;
  localparam logic [4:0] IT_STYPE  = 5'd2;
  localparam logic [4:0] IT_LTYPE  = 5'd3;
  localparam logic [4:0] IT_BTYPE  = 5'd4;
  localparam logic [4:0] IT_UTYPE  = 5'd5;
  localparam logic [4:0] IT_JRTYPE = 5'd6;

  function automatic logic is_mem(input logic [4:0] it);
    case (it)
      IT_STYPE, IT_LTYPE: is_mem = 1'b1;
      default:            is_mem = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [4:0] it);
    case (it)
      IT_STYPE: is_store = 1'b1;
      default:  is_store = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rf(input logic [4:0] it);
    case (it)
      IT_RTYPE, IT_ITYPE, IT_UTYPE, IT_LTYPE, IT_JRTYPE: writes_rf = 1'b1;
      default:                                          writes_rf = 1'b0;
    endcase
  endfunction

  // Branch outcome is already folded into the ALU result, so BTYPE always takes y.
  function automatic logic sel_alu_pc(input logic [4:0] it);
    case (it)
      IT_BTYPE, IT_JRTYPE: sel_alu_pc = 1'b1;
      default:             sel_alu_pc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Handshake and strobe bundle between the sequencer (master) and the
// imem/dmem/decode/alu/regfile environment (slave).
interface core_sequencer_if;
  logic       run_i;
  logic       imem_req_o;
  logic       imem_ack_i;
  logic       ir_load_o;
  logic       dec_valid_i;
  logic [4:0] itype_i;
  logic       readin_a_o;
  logic       readin_b_o;
  logic       readin_pass_o;
  logic [2:0] stage_o;
  logic       dmem_req_o;
  logic       dmem_we_o;
  logic       dmem_ack_i;
  logic       rf_we_o;
  logic       pc_load_o;
  logic       pc_sel_o;
  logic       retire_o;

  modport master (
    input  run_i, imem_ack_i, dec_valid_i, itype_i, dmem_ack_i,
    output imem_req_o, ir_load_o, readin_a_o, readin_b_o, readin_pass_o,
           stage_o, dmem_req_o, dmem_we_o, rf_we_o, pc_load_o, pc_sel_o, retire_o
  );

  modport slave (
    output run_i, imem_ack_i, dec_valid_i, itype_i, dmem_ack_i,
    input  imem_req_o, ir_load_o, readin_a_o, readin_b_o, readin_pass_o,
           stage_o, dmem_req_o, dmem_we_o, rf_we_o, pc_load_o, pc_sel_o, retire_o
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/LATCH/EXECUTE/MEMORY/WRITEBACK sequencer with all outputs registered.
// Define SEQ_SKIP_MEM_EN to let non-memory classes bypass the MEMORY stage.
module core_sequencer
  import core_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  core_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LATCH, S_EXEC, S_MEM, S_WB
  } state_t;

  state_t     state_r, next_state_s;
  logic [4:0] itype_r;
  logic [2:0] stage_r, stage_s;
  logic       imem_req_r, imem_req_s, ir_load_r, ir_load_s, readin_r, readin_s;
  logic       dmem_req_r, dmem_req_s, dmem_we_r, dmem_we_s;
  logic       rf_we_r, rf_we_s, pc_sel_r, pc_sel_s, wb_r, wb_s;

  // Next-state logic plus the output values that the next state will present.
  always_comb begin
    next_state_s = state_r;
    stage_s      = STG_IDLE;
    case (state_r)
      S_IDLE:   next_state_s = bus.run_i ? S_FETCH : S_IDLE;
      S_FETCH:  next_state_s = bus.imem_ack_i ? S_DECODE : S_FETCH;
      S_DECODE: next_state_s = bus.dec_valid_i ? S_LATCH : S_DECODE;
      S_LATCH:  next_state_s = S_EXEC;
`ifdef SEQ_SKIP_MEM_EN
      S_EXEC:   next_state_s = is_mem(itype_r) ? S_MEM : S_WB;
`else
      S_EXEC:   next_state_s = S_MEM;
`endif
      S_MEM:    next_state_s = (!is_mem(itype_r) || bus.dmem_ack_i) ? S_WB : S_MEM;
      S_WB:     next_state_s = bus.run_i ? S_FETCH : S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase

    case (next_state_s)
      S_IDLE:           stage_s = STG_IDLE;
      S_FETCH:          stage_s = STG_FETCH;
      S_DECODE, S_LATCH: stage_s = STG_DECODE;
      S_EXEC:           stage_s = STG_EXEC;
      S_MEM:            stage_s = STG_MEM;
      S_WB:             stage_s = STG_WB;
      default:          stage_s = STG_IDLE;
    endcase

    // itype_r is latched on DECODE->LATCH, so it is valid whenever MEMORY/WRITEBACK is next.
    imem_req_s = (next_state_s == S_FETCH);
    ir_load_s  = (state_r == S_FETCH) && (next_state_s == S_DECODE);
    readin_s   = (next_state_s == S_LATCH);
    dmem_req_s = (next_state_s == S_MEM) && is_mem(itype_r);
    dmem_we_s  = dmem_req_s && is_store(itype_r);
    wb_s       = (next_state_s == S_WB);
    rf_we_s    = wb_s && writes_rf(itype_r);
    pc_sel_s   = wb_s && sel_alu_pc(itype_r);
  end

  // State, latched instruction class and registered output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      itype_r    <= 5'd0;
      stage_r    <= STG_IDLE;
      imem_req_r <= 1'b0;
      ir_load_r  <= 1'b0;
      readin_r   <= 1'b0;
      dmem_req_r <= 1'b0;
      dmem_we_r  <= 1'b0;
      rf_we_r    <= 1'b0;
      pc_sel_r   <= 1'b0;
      wb_r       <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      if (state_r == S_DECODE && bus.dec_valid_i) begin
        itype_r <= bus.itype_i;
      end
      stage_r    <= stage_s;
      imem_req_r <= imem_req_s;
      ir_load_r  <= ir_load_s;
      readin_r   <= readin_s;
      dmem_req_r <= dmem_req_s;
      dmem_we_r  <= dmem_we_s;
      rf_we_r    <= rf_we_s;
      pc_sel_r   <= pc_sel_s;
      wb_r       <= wb_s;
    end
  end

  assign bus.stage_o       = stage_r;
  assign bus.imem_req_o    = imem_req_r;
  assign bus.ir_load_o     = ir_load_r;
  assign bus.readin_a_o    = readin_r;
  assign bus.readin_b_o    = readin_r;
  assign bus.readin_pass_o = readin_r;
  assign bus.dmem_req_o    = dmem_req_r;
  assign bus.dmem_we_o     = dmem_we_r;
  assign bus.rf_we_o       = rf_we_r;
  assign bus.pc_load_o     = wb_r;
  assign bus.pc_sel_o      = pc_sel_r;
  assign bus.retire_o      = wb_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: the stimulus queues the expected output
// vector for every cycle, a negedge monitor pops and compares.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_sequencer_if bus ();
  core_sequencer dut (.clk(clk), .reset(reset), .bus(bus.master));

  typedef struct {
    string       name;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // {imem_req, ir_load, ra, rb, rpass, stage[2:0], dmem_req, dmem_we, rf_we, pc_load, pc_sel, retire}
  function automatic exp_t ex(input string nm, input logic [2:0] stg, input logic imr, input logic irl,
                              input logic rd, input logic dr, input logic dw, input logic rf,
                              input logic pl, input logic ps, input logic rt);
    exp_t e;
    e.name = nm;
    e.v    = {imr, irl, rd, rd, rd, stg, dr, dw, rf, pl, ps, rt};
    return e;
  endfunction

  wire [13:0] act = {bus.imem_req_o, bus.ir_load_o, bus.readin_a_o, bus.readin_b_o, bus.readin_pass_o,
                     bus.stage_o, bus.dmem_req_o, bus.dmem_we_o, bus.rf_we_o, bus.pc_load_o,
                     bus.pc_sel_o, bus.retire_o};

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end

  task automatic step(input exp_t e);
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  // Runs one instruction starting from an observed FETCH cycle.
  task automatic instr(input string nm, input logic [4:0] it, input int dvwait, input int dwait,
                       input logic mem, input logic we, input logic rf, input logic ps,
                       input logic run_end);
    bus.run_i = 1'b1; bus.imem_ack_i = 1'b1; bus.dec_valid_i = 1'b0; bus.dmem_ack_i = 1'b0;
    step(ex({nm, "_dec"}, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.imem_ack_i = 1'b0;
    repeat (dvwait) step(ex({nm, "_decwait"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.dec_valid_i = 1'b1; bus.itype_i = it;
    step(ex({nm, "_latch"}, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.dec_valid_i = 1'b0; bus.itype_i = 5'd31;
    step(ex({nm, "_exec"}, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.run_i = run_end;
    if (mem) begin
      bus.imem_ack_i = 1'b1;
      step(ex({nm, "_mem"}, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, we, 1'b0, 1'b0, 1'b0, 1'b0));
      repeat (dwait) step(ex({nm, "_memwait"}, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, we, 1'b0, 1'b0, 1'b0, 1'b0));
      bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b1;
    end else begin
`ifndef SEQ_SKIP_MEM_EN
      step(ex({nm, "_mem"}, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
    end
    step(ex({nm, "_wb"}, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rf, 1'b1, ps, 1'b1));
    bus.dmem_ack_i = 1'b0;
    if (run_end) step(ex({nm, "_next"}, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    else         step(ex({nm, "_park"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    reset = 1'b1; bus.run_i = 1'b1; bus.imem_ack_i = 1'b0; bus.dec_valid_i = 1'b0;
    bus.itype_i = 5'd0; bus.dmem_ack_i = 1'b0;
    step(ex("rst0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(ex("rst1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0; bus.dmem_ack_i = 1'b1;
    step(ex("fetch", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(ex("fetch_stray_dack", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    //         name    itype      dvw dw  mem   we    rf    ps    run_end
    instr("add",  IT_RTYPE,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    instr("sw",   IT_STYPE,  1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    instr("lw",   IT_LTYPE,  0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    instr("jr",   IT_JRTYPE, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    instr("unk",  5'd31,     0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    instr("addi", IT_ITYPE,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    instr("lui",  IT_UTYPE,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    instr("beq",  IT_BTYPE,  0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(ex("idle_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset while a store waits on dmem_ack_i.
    bus.run_i = 1'b1;
    step(ex("abort_fetch", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.imem_ack_i = 1'b1;
    step(ex("abort_dec", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.imem_ack_i = 1'b0; bus.dec_valid_i = 1'b1; bus.itype_i = IT_STYPE;
    step(ex("abort_latch", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.dec_valid_i = 1'b0;
    step(ex("abort_exec", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(ex("abort_mem", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step(ex("abort_memwait", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1; bus.dmem_ack_i = 1'b1;
    step(ex("abort_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0; bus.run_i = 1'b0;
    step(ex("abort_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.dmem_ack_i = 1'b0;
    step(ex("abort_idle2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
